// File: rtl/cmd_sequencer.sv
// Command sequencer: applies UART command frames to attitude/thrust setpoints, sequences calibration
// and battery conversion, and returns a response byte. Optional link watchdog under CMD_WDOG_EN.
module cmd_sequencer #(
   parameter int SETTLE_W = 25,
   parameter int WD_W     = 26
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_rdy,
   input  logic [7:0]         cmd,
   input  logic [15:0]        data,
   output logic               clr_cmd_rdy,
   output logic [7:0]         resp,
   output logic               send_resp,
   input  logic               resp_sent,
   output logic signed [15:0] d_ptch,
   output logic signed [15:0] d_roll,
   output logic signed [15:0] d_yaw,
   output logic [8:0]         thrst,
   output logic               motors_off,
   output logic               strt_cal,
   output logic               inertial_cal,
   input  logic               cal_done,
   output logic               strt_cnv,
   input  logic               cnv_cmplt,
   input  logic [7:0]         batt
);

   localparam logic [7:0] REQ_BATT  = 8'h01;
   localparam logic [7:0] SET_PTCH  = 8'h02;
   localparam logic [7:0] SET_ROLL  = 8'h03;
   localparam logic [7:0] SET_YAW   = 8'h04;
   localparam logic [7:0] SET_THRST = 8'h05;
   localparam logic [7:0] CALIBRATE = 8'h06;
   localparam logic [7:0] EMER_LAND = 8'h07;
   localparam logic [7:0] MTRS_OFF  = 8'h08;
   localparam logic [7:0] POS_ACK   = 8'hA5;
   localparam logic [7:0] NEG_ACK   = 8'hEE;

   typedef enum logic [2:0] {IDLE, SETTLE, CAL, BATT, RESP_WAIT} state_t;

   state_t              state_r;
   logic [SETTLE_W-1:0] settle_cnt_r;
   logic                accept_s;

   assign accept_s = (state_r == IDLE) && cmd_rdy;

`ifdef CMD_WDOG_EN
   logic [WD_W-1:0] wd_cnt_r;
   logic            wd_fire_s;

   // An accepted frame in the terminal-count cycle suppresses the forced clear.
   assign wd_fire_s = (&wd_cnt_r) && !motors_off && !accept_s;
`endif

   // Sequencer state, counters and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         settle_cnt_r <= {SETTLE_W{1'b0}};
         clr_cmd_rdy  <= 1'b0;
         resp         <= 8'h00;
         send_resp    <= 1'b0;
         d_ptch       <= 16'sh0000;
         d_roll       <= 16'sh0000;
         d_yaw        <= 16'sh0000;
         thrst        <= 9'h000;
         motors_off   <= 1'b1;
         strt_cal     <= 1'b0;
         inertial_cal <= 1'b0;
         strt_cnv     <= 1'b0;
`ifdef CMD_WDOG_EN
         wd_cnt_r     <= {WD_W{1'b0}};
`endif
      end else begin
         clr_cmd_rdy <= 1'b0;
         send_resp   <= 1'b0;
         strt_cal    <= 1'b0;
         strt_cnv    <= 1'b0;
`ifdef CMD_WDOG_EN
         wd_cnt_r <= accept_s ? {WD_W{1'b0}} : wd_cnt_r + {{(WD_W-1){1'b0}}, 1'b1};
         if (wd_fire_s) begin
            d_ptch <= 16'sh0000;
            d_roll <= 16'sh0000;
            d_yaw  <= 16'sh0000;
            thrst  <= 9'h000;
         end
`endif
         case (state_r)
            IDLE: begin
               if (cmd_rdy) begin
                  clr_cmd_rdy <= 1'b1;
                  case (cmd)
                     SET_PTCH: begin
                        d_ptch <= data; resp <= POS_ACK; send_resp <= 1'b1; state_r <= RESP_WAIT;
                     end
                     SET_ROLL: begin
                        d_roll <= data; resp <= POS_ACK; send_resp <= 1'b1; state_r <= RESP_WAIT;
                     end
                     SET_YAW: begin
                        d_yaw <= data; resp <= POS_ACK; send_resp <= 1'b1; state_r <= RESP_WAIT;
                     end
                     SET_THRST: begin
                        thrst      <= data[8:0];
                        motors_off <= 1'b0;
                        resp       <= POS_ACK;
                        send_resp  <= 1'b1;
                        state_r    <= RESP_WAIT;
                     end
                     EMER_LAND: begin
                        d_ptch    <= 16'sh0000;
                        d_roll    <= 16'sh0000;
                        d_yaw     <= 16'sh0000;
                        thrst     <= 9'h000;
                        resp      <= POS_ACK;
                        send_resp <= 1'b1;
                        state_r   <= RESP_WAIT;
                     end
                     MTRS_OFF: begin
                        motors_off <= 1'b1;
                        thrst      <= 9'h000;
                        resp       <= POS_ACK;
                        send_resp  <= 1'b1;
                        state_r    <= RESP_WAIT;
                     end
                     CALIBRATE: begin
                        motors_off   <= 1'b0;
                        inertial_cal <= 1'b1;
                        d_ptch       <= 16'sh0000;
                        d_roll       <= 16'sh0000;
                        d_yaw        <= 16'sh0000;
                        thrst        <= 9'h000;
                        settle_cnt_r <= {SETTLE_W{1'b0}};
                        state_r      <= SETTLE;
                     end
                     REQ_BATT: begin
                        strt_cnv <= 1'b1;
                        state_r  <= BATT;
                     end
                     default: begin
                        resp <= NEG_ACK; send_resp <= 1'b1; state_r <= RESP_WAIT;
                     end
                  endcase
               end
            end
            SETTLE: begin
               // Motors spin up for 2^SETTLE_W cycles before calibration starts.
               settle_cnt_r <= settle_cnt_r + {{(SETTLE_W-1){1'b0}}, 1'b1};
               if (&settle_cnt_r) begin
                  strt_cal <= 1'b1;
                  state_r  <= CAL;
               end
            end
            CAL: begin
               if (cal_done) begin
                  inertial_cal <= 1'b0;
                  resp         <= POS_ACK;
                  send_resp    <= 1'b1;
                  state_r      <= RESP_WAIT;
               end
            end
            BATT: begin
               if (cnv_cmplt) begin
                  resp      <= batt;
                  send_resp <= 1'b1;
                  state_r   <= RESP_WAIT;
               end
            end
            RESP_WAIT: begin
               if (resp_sent) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Command sequencer between the UART command receiver and the flight controller / A2D battery monitor. It accepts one decoded command frame (8-bit opcode plus 16-bit data) at a time. It updates the desired pitch, roll, yaw and thrust setpoints, and sequences the multi-cycle operations: inertial calibration and battery conversion. It returns a one-byte response for every frame and, optionally, forces an emergency landing when the command link goes silent.

## Interface
Parameters:
- SETTLE_W, 25: width of the motor spin-up settle counter. Settle time is 2^SETTLE_W cycles.
- WD_W, 26: width of the link watchdog counter. Timeout is 2^WD_W cycles.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_rdy  in  1  a full frame is available on cmd and data
- cmd  in  8  opcode
- data  in  16  operand
- clr_cmd_rdy  out  1  one-cycle pulse acknowledging frame capture
- resp  out  8  response byte
- send_resp  out  1  one-cycle pulse requesting transmission of resp
- resp_sent  in  1  transmitter finished sending resp
- d_ptch, d_roll, d_yaw  out  16 each  signed desired attitude
- thrst  out  9  desired thrust, unsigned
- motors_off  out  1  force all ESC outputs to minimum
- strt_cal  out  1  one-cycle pulse that starts inertial calibration
- inertial_cal  out  1  high for the whole calibration sequence
- cal_done  in  1  inertial interface finished calibration
- strt_cnv  out  1  one-cycle pulse that starts the A2D battery conversion
- cnv_cmplt  in  1  A2D result valid
- batt  in  8  battery reading, upper 8 bits of the A2D result

## Operation
Opcodes:
- 01 REQ_BATT
- 02 SET_PTCH
- 03 SET_ROLL
- 04 SET_YAW
- 05 SET_THRST
- 06 CALIBRATE
- 07 EMER_LAND
- 08 MTRS_OFF

Response codes:
- Positive ack: 8'hA5.
- Negative ack (unknown opcode): 8'hEE.

States are IDLE, SETTLE, CAL, BATT and RESP_WAIT.

IDLE:
- A frame is accepted only in IDLE with cmd_rdy=1. While the block is in any other state, cmd_rdy is ignored and the frame stays pending.
- SET_PTCH, SET_ROLL, SET_YAW: data is loaded verbatim into the matching register, with no sign manipulation. Response is A5. Next state is RESP_WAIT.
- SET_THRST: thrst loads data[8:0] and motors_off clears. Response is A5. Next state is RESP_WAIT.
- EMER_LAND: d_ptch, d_roll, d_yaw and thrst are all set to 0. motors_off is unchanged. Response is A5. Next state is RESP_WAIT.
- MTRS_OFF: motors_off is set to 1 and thrst to 0. Response is A5. Next state is RESP_WAIT.
- CALIBRATE: motors_off clears, inertial_cal rises, d_ptch, d_roll, d_yaw and thrst clear to 0, and the settle counter clears. Next state is SETTLE.
- REQ_BATT: strt_cnv pulses. Next state is BATT.
- Any other opcode: response is EE. Next state is RESP_WAIT.

SETTLE:
- The counter increments each cycle.
- At its terminal count the block pulses strt_cal and moves to CAL.

CAL:
- On cal_done, inertial_cal falls, resp is A5 and send_resp pulses. Next state is RESP_WAIT.

BATT:
- On cnv_cmplt, resp takes batt and send_resp pulses. Next state is RESP_WAIT.

RESP_WAIT:
- On resp_sent the block returns to IDLE.
- resp_sent seen in any other state is ignored.

Boundary conditions:
- Arithmetic: the settle and watchdog counters are plain binary counters. There is no other arithmetic; setpoints are pure register loads.
- rst asserted in any state returns the block to IDLE with all outputs at their reset values on the next edge. Any calibration or conversion in progress is abandoned.
- cal_done or cnv_cmplt seen while not in CAL or BATT respectively is ignored.

## Timing
- All outputs are registered.
- Reset values:
  - d_ptch, d_roll, d_yaw and thrst = 0.
  - motors_off = 1.
  - resp = 0.
  - All pulses and inertial_cal = 0.
  - State = IDLE. All counters = 0.
- Frame accepted on edge T (IDLE, cmd_rdy=1): clr_cmd_rdy is high in cycle T+1.
- Simple commands (register updates, no wait state): the setpoint change, resp and the send_resp pulse are all visible in cycle T+1.
- REQ_BATT: strt_cnv is high in cycle T+1. send_resp pulses in the cycle after cnv_cmplt is sampled.
- CALIBRATE: strt_cal pulses exactly 2^SETTLE_W cycles after entering SETTLE. send_resp pulses in the cycle after cal_done is sampled.
- Earliest next acceptance is the cycle after resp_sent is sampled.

## Configuration
Macro: CMD_WDOG_EN.
- Defined: a WD_W-bit counter clears on every accepted frame and increments otherwise.
- On reaching its terminal count with motors_off=0, it forces d_ptch, d_roll, d_yaw and thrst to 0 in the next cycle, then wraps and keeps counting.
- It sends no response and does not change state.
- If a frame is accepted in the same cycle as the terminal count, the frame wins and the counter clears.
- Undefined: no watchdog logic exists and setpoints change only by command.

## Test plan
- Reset, then SET_PTCH 002A, SET_ROLL 003A, SET_YAW FF1F (resp_sent returned 20 cycles after each send_resp) -> d_ptch=002A, d_roll=003A, d_yaw=FF1F; three send_resp pulses, each with resp=A5.
- SET_THRST 01FF then MTRS_OFF -> thrst=1FF and motors_off=0 after the first frame; thrst=0 and motors_off=1 after the second.
- CALIBRATE with SETTLE_W=4, cal_done raised 30 cycles after strt_cal -> strt_cal exactly 16 cycles after entering SETTLE; inertial_cal high throughout; all setpoints 0; resp=A5 only after cal_done.
- REQ_BATT with cnv_cmplt after 10 cycles, batt=C3 -> one strt_cnv pulse, then resp=C3 with send_resp; a second frame held on cmd_rdy is not accepted until resp_sent.
- Opcode 0x2B -> resp=EE and no setpoint changes. Assert rst while in SETTLE -> all outputs return to their reset values and the block is in IDLE.
- With CMD_WDOG_EN defined and WD_W=6: SET_THRST 0100, then silence -> thrst=0 exactly 64 cycles after the frame accept. Repeat with a frame accepted at count 63 -> no forced clear.
